branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the 5-stage RV32I pipeline. It sits beside the fetch stage. Each cycle it looks up the fetch PC in a direct-mapped branch target buffer (BTB) holding 2-bit saturating counters and supplies a predicted next PC. The execute stage returns each resolved branch or jump. The block updates its tables, flags mispredictions, supplies the redirect PC, and keeps branch and mispredict counters for debug.

## Interface
- IDX_W, default 6: BTB index width; table has 2^IDX_W entries; tag is pc[31:IDX_W+2].
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_pc_F  in  32  fetch-stage PC to look up.
- o_pred_taken  out  1  prediction for i_pc_F is taken.
- o_pred_target  out  32  predicted next PC for i_pc_F.
- i_clr  in  1  synchronous invalidate of all BTB entries.
- i_upd_vld  in  1  a resolved control-transfer instruction is in EX this cycle.
- i_upd_pc  in  32  PC of the resolved instruction.
- i_upd_is_jump  in  1  the resolved instruction is JAL or JALR.
- i_upd_taken  in  1  actual branch outcome; ignored when i_upd_is_jump=1.
- i_upd_target  in  32  actual target (ALU result).
- i_upd_pred_taken  in  1  prediction that was made for this instruction at fetch, carried down the pipe.
- i_upd_pred_target  in  32  predicted target that was carried down the pipe.
- o_mispred  out  1  misprediction detected; the pipeline must flush D/E.
- o_redirect_pc  out  32  correct next PC when o_mispred=1.
- o_br_cnt  out  32  count of resolved updates.
- o_mispred_cnt  out  32  count of mispredictions.

## Operation
- Entry fields: valid, tag, target[31:1], ctr[1:0].
- Lookup is combinational:
  - idx = i_pc_F[IDX_W+1:2].
  - hit = valid & (tag == i_pc_F[31:IDX_W+2]).
  - o_pred_taken = hit & ctr[1].
  - o_pred_target = o_pred_taken ? {target[31:1],1'b0} : i_pc_F+4.
- Actual outcome: act = i_upd_is_jump | i_upd_taken.
- o_mispred = i_upd_vld & ((act != i_upd_pred_taken) | (act & (i_upd_target[31:1] != i_upd_pred_target[31:1]))). It is combinational.
- o_redirect_pc = act ? {i_upd_target[31:1],1'b0} : i_upd_pc+4. It is valid only when o_mispred=1.
- Update happens on the edge when i_upd_vld=1 and i_clr=0. The entry is indexed by i_upd_pc.
  - Hit, jump: ctr<=11, target<=i_upd_target.
  - Hit, branch taken: ctr saturating +1 (max 11), target<=i_upd_target.
  - Hit, branch not taken: ctr saturating −1 (min 00); target unchanged.
  - Miss, act=1: allocate (overwrite): valid<=1, tag, target, ctr <= jump ? 11 : 10.
  - Miss, act=0: no change.
- Performance counters, when i_upd_vld=1:
  - o_br_cnt += 1.
  - o_mispred_cnt += o_mispred.
  - Both wrap modulo 2^32 and are not affected by i_clr.
- i_clr=1: all valid bits <= 0 on the edge. It takes priority over a same-cycle update: the update is dropped, but the perf counters still count it.
- PC arithmetic is 32-bit modulo. +4 wraps 0xFFFFFFFC to 0x00000000. Target bit 0 is always forced to 0.

## Timing
- Lookup: zero latency, same cycle as i_pc_F.
- Update: visible to lookups from the cycle after the edge. A same-cycle lookup to the same index sees old contents; there is no bypass.
- o_mispred and o_redirect_pc: same cycle as i_upd_vld. The pipeline redirects the PC at the next edge.
- Reset (async, i_reset=0):
  - All valid=0, all ctr=00.
  - o_br_cnt=0, o_mispred_cnt=0.
  - o_pred_taken=0, o_pred_target=i_pc_F+4.
  - Mid-operation reset discards any pending update.
- Tag/target/ctr storage need not be reset; only valid bits and perf counters are.
- Aliasing: two PCs with the same idx and different tags evict each other on taken allocation. No reset of ctr occurs on a not-taken miss.

## Test plan
- Reset, then i_pc_F=0x100 → o_pred_taken=0, o_pred_target=0x104, both counters 0.
- Branch at 0x100, taken to 0x80, predicted not-taken → o_mispred=1, o_redirect_pc=0x80. Next cycle a lookup of 0x100 gives taken, target 0x80, ctr=10.
- Same branch resolved not-taken twice after allocation → ctr 10→01→00. A lookup then predicts not-taken (0x104). o_mispred=1 on the first not-taken update only; a further not-taken update stays saturated at 00.
- JALR at 0x200 to 0x301 → stored target 0x300, ctr=11. A repeat with pred_target 0x300 gives o_mispred=0. A repeat with actual 0x400 gives o_mispred=1, redirect 0x400.
- IDX_W=6: allocate taken branches at 0x100 and 0x200 (same idx 0) → the second evicts the first, and a lookup of 0x100 misses. Then pulse i_clr together with an update → all lookups miss, but o_br_cnt still increments.
- Drive 2^32−1 preset via forced counter, then one update → o_br_cnt wraps to 0. Update at 0xFFFFFFFC not taken, predicted taken → redirect 0x00000000.

Source files
------------

// File: rtl/branch_predictor_if.sv
//------------------------------------------------------------------------------
// branch_predictor_if - fetch lookup / execute resolve bundle, rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface branch_predictor_if;
   logic [31:0] i_pc_F;
   logic        o_pred_taken;
   logic [31:0] o_pred_target;
   logic        i_clr;
   logic        i_upd_vld;
   logic [31:0] i_upd_pc;
   logic        i_upd_is_jump;
   logic        i_upd_taken;
   logic [31:0] i_upd_target;
   logic        i_upd_pred_taken;
   logic [31:0] i_upd_pred_target;
   logic        o_mispred;
   logic [31:0] o_redirect_pc;
   logic [31:0] o_br_cnt;
   logic [31:0] o_mispred_cnt;

   modport master (
      output i_pc_F, i_clr, i_upd_vld, i_upd_pc, i_upd_is_jump, i_upd_taken,
             i_upd_target, i_upd_pred_taken, i_upd_pred_target,
      input  o_pred_taken, o_pred_target, o_mispred, o_redirect_pc,
             o_br_cnt, o_mispred_cnt
   );

   modport slave (
      input  i_pc_F, i_clr, i_upd_vld, i_upd_pc, i_upd_is_jump, i_upd_taken,
             i_upd_target, i_upd_pred_taken, i_upd_pred_target,
      output o_pred_taken, o_pred_target, o_mispred, o_redirect_pc,
             o_br_cnt, o_mispred_cnt
   );
endinterface

`default_nettype wire

// File: rtl/branch_predictor.sv
//------------------------------------------------------------------------------
// branch_predictor - direct-mapped BTB with 2-bit counters, rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_predictor #(
   parameter int IDX_W = 6
) (
   input  wire logic         i_clk,
   input  wire logic         i_reset,
   branch_predictor_if.slave bp
);
   localparam int C_ENTRIES = 1 << IDX_W;
   localparam int C_TAG_W   = 32 - IDX_W - 2;

   logic [C_ENTRIES-1:0] r_valid;
   logic [C_TAG_W-1:0]   r_tag    [C_ENTRIES];
   logic [30:0]          r_target [C_ENTRIES];
   logic [1:0]           r_ctr    [C_ENTRIES];
   logic [31:0]          r_br_cnt;
   logic [31:0]          r_mispred_cnt;

   // ---------------- fetch-side lookup ----------------
   logic [IDX_W-1:0] w_f_idx;
   logic             w_f_hit;
   logic             w_f_taken;

   assign w_f_idx   = bp.i_pc_F[IDX_W+1:2];
   assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == bp.i_pc_F[31:IDX_W+2]);
   assign w_f_taken = w_f_hit && r_ctr[w_f_idx][1];

   assign bp.o_pred_taken  = w_f_taken;
   assign bp.o_pred_target = w_f_taken ? {r_target[w_f_idx], 1'b0}
                                       : bp.i_pc_F + 32'd4;

   // ---------------- execute-side resolve ----------------
   logic             w_act;
   logic             w_mispred;
   logic [IDX_W-1:0] w_u_idx;
   logic             w_u_hit;
   logic             w_upd_en;
   logic             w_wr_entry;
   logic             w_wr_target;
   logic [1:0]       w_ctr_old;
   logic [1:0]       w_ctr_nxt;

   assign w_act     = bp.i_upd_is_jump | bp.i_upd_taken;
   // Only target[31:1] is stored, so bit 0 never counts as a target mismatch
   assign w_mispred = bp.i_upd_vld &
                      ((w_act != bp.i_upd_pred_taken) |
                       (w_act & (bp.i_upd_target[31:1] != bp.i_upd_pred_target[31:1])));

   assign bp.o_mispred     = w_mispred;
   assign bp.o_redirect_pc = w_act ? {bp.i_upd_target[31:1], 1'b0}
                                   : bp.i_upd_pc + 32'd4;

   assign w_u_idx     = bp.i_upd_pc[IDX_W+1:2];
   assign w_u_hit     = r_valid[w_u_idx] && (r_tag[w_u_idx] == bp.i_upd_pc[31:IDX_W+2]);
   assign w_upd_en    = bp.i_upd_vld & ~bp.i_clr;
   assign w_wr_entry  = w_upd_en & (w_u_hit | w_act);
   assign w_wr_target = w_upd_en & w_act;
   assign w_ctr_old   = r_ctr[w_u_idx];

   always_comb begin
      w_ctr_nxt = w_ctr_old;
      if (!w_u_hit) begin
         w_ctr_nxt = bp.i_upd_is_jump ? 2'b11 : 2'b10;
      end else if (bp.i_upd_is_jump) begin
         w_ctr_nxt = 2'b11;
      end else if (bp.i_upd_taken) begin
         if (w_ctr_old != 2'b11) w_ctr_nxt = w_ctr_old + 2'd1;
      end else begin
         if (w_ctr_old != 2'b00) w_ctr_nxt = w_ctr_old - 2'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_valid       <= '0;
         r_br_cnt      <= '0;
         r_mispred_cnt <= '0;
         for (int i = 0; i < C_ENTRIES; i++) begin
            r_ctr[i] <= 2'b00;
         end
      end else begin
         if (bp.i_clr) begin
            r_valid <= '0;
         end else if (w_wr_entry) begin
            r_valid[w_u_idx] <= 1'b1;
            r_ctr[w_u_idx]   <= w_ctr_nxt;
         end
         // Counters track every resolved instruction, even when clear drops it
         if (bp.i_upd_vld) begin
            r_br_cnt      <= r_br_cnt + 32'd1;
            r_mispred_cnt <= r_mispred_cnt + {31'd0, w_mispred};
         end
      end
   end

   // Tag/target need no reset: they are only observed through a set valid bit
   always_ff @(posedge i_clk) begin
      if (w_wr_target) begin
         r_tag[w_u_idx]    <= bp.i_upd_pc[31:IDX_W+2];
         r_target[w_u_idx] <= bp.i_upd_target[31:1];
      end
   end

   assign bp.o_br_cnt      = r_br_cnt;
   assign bp.o_mispred_cnt = r_mispred_cnt;

   logic w_unused_bits;
   assign w_unused_bits = ^{bp.i_upd_target[0], bp.i_upd_pred_target[0]};

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
//------------------------------------------------------------------------------
// tb_branch_predictor - directed self-checking bench, rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_predictor;
   logic i_clk;
   logic i_reset;
   int   n_vec;
   int   n_err;

   branch_predictor_if bif ();

   branch_predictor #(.IDX_W(6)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bp      (bif)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      bif.i_clr             = 1'b0;
      bif.i_upd_vld         = 1'b0;
      bif.i_upd_pc          = 32'h0;
      bif.i_upd_is_jump     = 1'b0;
      bif.i_upd_taken       = 1'b0;
      bif.i_upd_target      = 32'h0;
      bif.i_upd_pred_taken  = 1'b0;
      bif.i_upd_pred_target = 32'h0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic jmp, input logic tkn,
                      input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
      bif.i_upd_vld         = 1'b1;
      bif.i_upd_pc          = pc;
      bif.i_upd_is_jump     = jmp;
      bif.i_upd_taken       = tkn;
      bif.i_upd_target      = tgt;
      bif.i_upd_pred_taken  = pt;
      bif.i_upd_pred_target = ptgt;
   endtask

   task automatic look(input string tag, input logic [31:0] pc,
                       input logic tkn, input logic [31:0] tgt);
      bif.i_pc_F = pc;
      #1;
      chk({tag, "_taken"}, {31'd0, bif.o_pred_taken}, {31'd0, tkn});
      chk({tag, "_target"}, bif.o_pred_target, tgt);
   endtask

   task automatic resolve(input string tag, input logic mp, input logic [31:0] rd);
      #1;
      chk({tag, "_mispred"}, {31'd0, bif.o_mispred}, {31'd0, mp});
      if (mp) chk({tag, "_redirect"}, bif.o_redirect_pc, rd);
   endtask

   task automatic counts(input string tag, input logic [31:0] br, input logic [31:0] mp);
      chk({tag, "_br_cnt"}, bif.o_br_cnt, br);
      chk({tag, "_mp_cnt"}, bif.o_mispred_cnt, mp);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      i_reset = 1'b0;
      bif.i_pc_F = 32'h100;
      idle();
      #2;
      look("rst", 32'h100, 1'b0, 32'h104);
      counts("rst", 32'd0, 32'd0);
      tick();
      i_reset = 1'b1;
      tick();

      // Taken branch at 0x100 allocates ctr=10; same-cycle lookup still sees old state
      upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
      resolve("alloc", 1'b1, 32'h80);
      look("nobypass", 32'h100, 1'b0, 32'h104);
      tick();
      idle();
      look("alloc_look", 32'h100, 1'b1, 32'h80);
      chk("alloc_ctr", {30'd0, dut.r_ctr[0]}, 32'd2);
      counts("alloc", 32'd1, 32'd1);

      // Two not-taken updates walk ctr 10->01->00, then stay saturated
      upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
      resolve("nt1", 1'b1, 32'h104);
      tick();
      chk("nt1_ctr", {30'd0, dut.r_ctr[0]}, 32'd1);
      upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
      resolve("nt2", 1'b0, 32'h104);
      tick();
      chk("nt2_ctr", {30'd0, dut.r_ctr[0]}, 32'd0);
      upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
      resolve("nt3", 1'b0, 32'h104);
      tick();
      idle();
      chk("nt3_ctr", {30'd0, dut.r_ctr[0]}, 32'd0);
      look("nt_look", 32'h100, 1'b0, 32'h104);
      counts("nt", 32'd4, 32'd2);

      // JALR 0x200 -> 0x301 evicts 0x100 (same index), stores 0x300, ctr=11
      upd(32'h200, 1'b1, 1'b0, 32'h301, 1'b0, 32'h204);
      resolve("jalr", 1'b1, 32'h300);
      tick();
      idle();
      chk("jalr_ctr", {30'd0, dut.r_ctr[0]}, 32'd3);
      look("jalr_look", 32'h200, 1'b1, 32'h300);
      look("jalr_evict", 32'h100, 1'b0, 32'h104);
      upd(32'h200, 1'b1, 1'b0, 32'h301, 1'b1, 32'h300);
      resolve("jalr_ok", 1'b0, 32'h300);
      tick();
      upd(32'h200, 1'b1, 1'b0, 32'h400, 1'b1, 32'h300);
      resolve("jalr_tgt", 1'b1, 32'h400);
      tick();
      idle();
      look("jalr_new", 32'h200, 1'b1, 32'h400);
      counts("jalr", 32'd7, 32'd4);

      // Taken-branch aliasing: 0x100 then 0x200 evict each other
      upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
      resolve("alias1", 1'b1, 32'h80);
      tick();
      idle();
      look("alias1_hit", 32'h100, 1'b1, 32'h80);
      look("alias1_miss", 32'h200, 1'b0, 32'h204);
      upd(32'h200, 1'b0, 1'b1, 32'h240, 1'b0, 32'h204);
      resolve("alias2", 1'b1, 32'h240);
      tick();
      idle();
      look("alias2_hit", 32'h200, 1'b1, 32'h240);
      look("alias2_miss", 32'h100, 1'b0, 32'h104);
      counts("alias", 32'd9, 32'd6);

      // Clear wins over a same-cycle update, counters still count it
      upd(32'h104, 1'b1, 1'b0, 32'h10, 1'b0, 32'h108);
      resolve("idx1", 1'b1, 32'h10);
      tick();
      idle();
      look("idx1_hit", 32'h104, 1'b1, 32'h10);
      upd(32'h108, 1'b0, 1'b1, 32'h50, 1'b0, 32'h10c);
      bif.i_clr = 1'b1;
      resolve("clr", 1'b1, 32'h50);
      tick();
      idle();
      look("clr_a", 32'h200, 1'b0, 32'h204);
      look("clr_b", 32'h104, 1'b0, 32'h108);
      look("clr_c", 32'h108, 1'b0, 32'h10c);
      counts("clr", 32'd11, 32'd8);

      // Counter wrap and PC+4 wrap at the top of the address space
      force dut.r_br_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_br_cnt;
      #1;
      chk("preset_br_cnt", bif.o_br_cnt, 32'hFFFF_FFFF);
      look("top_look", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
      upd(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40);
      resolve("top", 1'b1, 32'h0000_0000);
      tick();
      idle();
      counts("wrap", 32'd0, 32'd9);

      // Asynchronous reset mid-cycle drops a pending update
      upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
      #1;
      i_reset = 1'b0;
      #1;
      counts("arst", 32'd0, 32'd0);
      look("arst_look", 32'h200, 1'b0, 32'h204);
      tick();
      idle();
      #1;
      i_reset = 1'b1;
      tick();
      look("arst_drop", 32'h100, 1'b0, 32'h104);
      counts("arst_after", 32'd0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, observed running required finished");
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
